// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension issue sequencer: funct3 codes, MCycle op codes, FSM states.
package muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        OP_SMUL = 2'b00,
        OP_UMUL = 2'b01,
        OP_SDIV = 2'b10,
        OP_UDIV = 2'b11
    } mcycle_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10,
        DONE  = 2'b11
    } state_e;

    // MULHSU runs as an unsigned multiply and is corrected afterwards.
    function automatic logic [1:0] funct3ToOp(input logic [2:0] funct3);
        logic [1:0] op;
        op = OP_SMUL;
        case (funct3)
            F3_MUL, F3_MULH:    op = OP_SMUL;
            F3_MULHSU, F3_MULHU: op = OP_UMUL;
            F3_DIV, F3_REM:     op = OP_SDIV;
            default:            op = OP_UDIV;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/muldiv_issue_if.sv
// Bundle of the pipeline-side and MCycle-side signals of the mul/div issue sequencer.
interface muldiv_issue_if #(
    parameter int WIDTH = 32
);
    logic             MulDivValid;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] RS1;
    logic [WIDTH-1:0] RS2;
    logic             Stall;
    logic             ResultValid;
    logic [WIDTH-1:0] MulDivResult;
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;

    modport slave (
        input  MulDivValid, Funct3, RS1, RS2, Result1, Result2, Busy,
        output Stall, ResultValid, MulDivResult, Start, MCycleOp, Operand1, Operand2
    );

    modport master (
        output MulDivValid, Funct3, RS1, RS2, Result1, Result2, Busy,
        input  Stall, ResultValid, MulDivResult, Start, MCycleOp, Operand1, Operand2
    );
endinterface

// File: rtl/muldiv_fixup.sv
// Combinational result select, MULHSU correction and divide-by-zero/overflow bypass detection.
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic [WIDTH-1:0] result1_i,
    input  logic [WIDTH-1:0] result2_i,
    output logic [1:0]       mcycleOp_o,
    output logic             bypass_o,
    output logic [WIDTH-1:0] bypassResult_o,
    output logic [WIDTH-1:0] selResult_o
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic isDiv;
    logic isRem;
    logic divZero;
    logic divOverflow;

    assign mcycleOp_o = funct3ToOp(funct3_i);

    always_comb begin
        isDiv          = funct3_i[2];
        isRem          = funct3_i[2] & funct3_i[1];
        divZero        = isDiv && (rs2_i == '0);
        divOverflow    = isDiv && !funct3_i[0] && (rs1_i == MIN_VAL) && (rs2_i == '1);
        bypass_o       = divZero || divOverflow;
        bypassResult_o = '0;
        if (divZero) begin
            bypassResult_o = isRem ? rs1_i : '1;
        end else if (divOverflow) begin
            bypassResult_o = isRem ? '0 : MIN_VAL;
        end
    end

    // A negative RS1 read as unsigned adds RS2 * 2^WIDTH, so the high word is off by RS2.
    always_comb begin
        selResult_o = result1_i;
        case (funct3_i)
            F3_MUL, F3_DIV, F3_DIVU:           selResult_o = result1_i;
            F3_MULH, F3_MULHU, F3_REM, F3_REMU: selResult_o = result2_i;
            F3_MULHSU: selResult_o = result2_i - (rs1_i[WIDTH-1] ? rs2_i : '0);
            default:                            selResult_o = result1_i;
        endcase
    end

endmodule

// File: rtl/muldiv_issue.sv
// Issue/completion sequencer between EX and the MCycle mul/div unit.
// Optional result reuse across matching requests is enabled by defining MULDIV_REUSE_EN.
module muldiv_issue
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    muldiv_issue_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             stall;
    logic             start;
    logic             reuseHit;
    logic [WIDTH-1:0] fixResult1;
    logic [WIDTH-1:0] fixResult2;
    logic [1:0]       mcycleOp;
    logic             bypass;
    logic [WIDTH-1:0] bypassResult;
    logic [WIDTH-1:0] selResult;

    muldiv_fixup #(.WIDTH(WIDTH)) fixup (
        .funct3_i       (bus.Funct3),
        .rs1_i          (bus.RS1),
        .rs2_i          (bus.RS2),
        .result1_i      (fixResult1),
        .result2_i      (fixResult2),
        .mcycleOp_o     (mcycleOp),
        .bypass_o       (bypass),
        .bypassResult_o (bypassResult),
        .selResult_o    (selResult)
    );

`ifdef MULDIV_REUSE_EN
    logic             reuseValid_q;
    logic [WIDTH-1:0] reuseRs1_q, reuseRs2_q;
    logic [1:0]       reuseOp_q;
    logic [WIDTH-1:0] reuseR1_q, reuseR2_q;

    // Low product is signedness-independent, so a stored mul of either kind serves a later MUL.
    always_comb begin
        reuseHit = reuseValid_q && (bus.RS1 == reuseRs1_q) && (bus.RS2 == reuseRs2_q) &&
                   ((reuseOp_q == mcycleOp) || ((bus.Funct3 == F3_MUL) && !reuseOp_q[1]));
        fixResult1 = bus.Result1;
        fixResult2 = bus.Result2;
        if (state_q == IDLE && reuseHit) begin
            fixResult1 = reuseR1_q;
            fixResult2 = reuseR2_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            reuseValid_q <= 1'b0;
            reuseRs1_q   <= '0;
            reuseRs2_q   <= '0;
            reuseOp_q    <= '0;
            reuseR1_q    <= '0;
            reuseR2_q    <= '0;
        end else if (state_q == BUSY && !bus.Busy) begin
            reuseValid_q <= 1'b1;
            reuseRs1_q   <= bus.RS1;
            reuseRs2_q   <= bus.RS2;
            reuseOp_q    <= mcycleOp;
            reuseR1_q    <= bus.Result1;
            reuseR2_q    <= bus.Result2;
        end else if (state_q == IDLE && bus.MulDivValid && (bypass || reuseHit)) begin
            reuseValid_q <= 1'b0;
        end
    end
`else
    assign reuseHit   = 1'b0;
    assign fixResult1 = bus.Result1;
    assign fixResult2 = bus.Result2;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    // Start follows Busy while waiting so it drops in the completion cycle and MCycle cannot restart.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        stall    = 1'b0;
        start    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MulDivValid) begin
                    stall = 1'b1;
                    if (bypass) begin
                        result_d = bypassResult;
                        state_d  = DONE;
                    end else if (reuseHit) begin
                        result_d = selResult;
                        state_d  = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                stall = 1'b1;
                start = 1'b1;
                if (bus.Busy) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                start = bus.Busy;
                if (!bus.Busy) begin
                    result_d = selResult;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Stall        = stall;
    assign bus.Start        = start;
    assign bus.ResultValid  = (state_q == DONE);
    assign bus.MulDivResult = result_q;
    assign bus.MCycleOp     = mcycleOp;
    assign bus.Operand1     = bus.RS1;
    assign bus.Operand2     = bus.RS2;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed testbench for muldiv_issue at WIDTH=4 with a behavioural 3-cycle MCycle unit.
module tb_muldiv_issue;
    import muldiv_pkg::*;

    localparam int W   = 4;
    localparam int LAT = 3;
    localparam int ISSUE_STALL = LAT + 2;
`ifdef MULDIV_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    muldiv_issue_if #(.WIDTH(W)) bus ();

    muldiv_issue #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural MCycle: Busy rises with Start when idle, falls in the last compute cycle.
    logic         mcRunning;
    logic [1:0]   mcCount;
    logic [W-1:0] mcR1, mcR2;

    function automatic logic [2*W-1:0] mcCompute(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sp;
        logic signed [W-1:0]   sq, sr;
        logic [2*W-1:0]        res;
        res = '0;
        case (op)
            2'b00: begin
                sp  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                res = sp;
            end
            2'b01: res = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            2'b10: begin
                if (b == '0) res = {a, {W{1'b1}}};
                else begin
                    sq  = $signed(a) / $signed(b);
                    sr  = $signed(a) % $signed(b);
                    res = {sr, sq};
                end
            end
            default: res = (b == '0) ? {a, {W{1'b1}}} : {a % b, a / b};
        endcase
        return res;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mcRunning <= 1'b0;
            mcCount   <= '0;
            mcR1      <= '0;
            mcR2      <= '0;
        end else if (!mcRunning && bus.Start) begin
            mcRunning     <= 1'b1;
            mcCount       <= '0;
            {mcR2, mcR1}  <= mcCompute(bus.MCycleOp, bus.Operand1, bus.Operand2);
        end else if (mcRunning) begin
            if (mcCount == 2'(LAT - 1)) mcRunning <= 1'b0;
            else                        mcCount <= mcCount + 2'd1;
        end
    end

    assign bus.Busy    = mcRunning ? (mcCount != 2'(LAT - 1)) : bus.Start;
    assign bus.Result1 = mcR1;
    assign bus.Result2 = mcR2;

    // Every comparison goes through here so counting and reporting stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents one request, holds it until ResultValid, then checks result, stall length and issue.
    task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] expRes,
                                 input bit expStart, input int expStall, input logic [1:0] expOp);
        int           cyc;
        int           stallCnt;
        bit           seenStart;
        bit           seenValid;
        logic [1:0]   opSeen;
        logic [W-1:0] res;
        cyc = 0; stallCnt = 0; seenStart = 0; seenValid = 0; opSeen = '0; res = 'x;
        @(negedge clk);
        bus.MulDivValid = 1'b1;
        bus.Funct3 = f3;
        bus.RS1 = a;
        bus.RS2 = b;
        while (!seenValid && cyc < 40) begin
            #1;
            if (bus.Start) begin
                seenStart = 1;
                opSeen = bus.MCycleOp;
            end
            if (bus.Stall) stallCnt++;
            if (bus.ResultValid) begin
                seenValid = 1;
                res = bus.MulDivResult;
            end else begin
                @(negedge clk);
            end
            cyc++;
        end
        checkOutput({tag, "/valid"}, 32'(seenValid), 32'd1);
        checkOutput({tag, "/result"}, 32'(res), 32'(expRes));
        checkOutput({tag, "/stall"}, 32'(stallCnt), 32'(expStall));
        checkOutput({tag, "/start"}, 32'(seenStart), 32'(expStart));
        if (expStart) checkOutput({tag, "/op"}, 32'(opSeen), 32'(expOp));
        @(negedge clk);
        bus.MulDivValid = 1'b0;
        #1;
        checkOutput({tag, "/pulse"}, 32'(bus.ResultValid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.MulDivValid = 1'b0;
        bus.Funct3 = '0;
        bus.RS1 = '0;
        bus.RS2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset/stall", 32'(bus.Stall), 32'd0);
        checkOutput("reset/start", 32'(bus.Start), 32'd0);
        checkOutput("reset/valid", 32'(bus.ResultValid), 32'd0);
        checkOutput("reset/result", 32'(bus.MulDivResult), 32'd0);

        applyStimulus("mulhu_ff",  F3_MULHU,  4'hF, 4'hF, 4'hE, 1'b1, ISSUE_STALL, 2'b01);
        applyStimulus("mul_ff",    F3_MUL,    4'hF, 4'hF, 4'h1, !REUSE, REUSE ? 1 : ISSUE_STALL, 2'b00);
        applyStimulus("mulhsu_f3", F3_MULHSU, 4'hF, 4'h3, 4'hF, 1'b1, ISSUE_STALL, 2'b01);
        applyStimulus("mulh_dd",   F3_MULH,   4'hD, 4'hD, 4'h0, 1'b1, ISSUE_STALL, 2'b00);
        applyStimulus("div_7d",    F3_DIV,    4'h7, 4'hD, 4'hE, 1'b1, ISSUE_STALL, 2'b10);
        applyStimulus("rem_7d",    F3_REM,    4'h7, 4'hD, 4'h1, !REUSE, REUSE ? 1 : ISSUE_STALL, 2'b10);
        applyStimulus("divu_c8",   F3_DIVU,   4'hC, 4'h8, 4'h1, 1'b1, ISSUE_STALL, 2'b11);
        applyStimulus("divu_z",    F3_DIVU,   4'h5, 4'h0, 4'hF, 1'b0, 1, 2'b11);
        applyStimulus("remu_z",    F3_REMU,   4'h5, 4'h0, 4'h5, 1'b0, 1, 2'b11);
        applyStimulus("div_ovf",   F3_DIV,    4'h8, 4'hF, 4'h8, 1'b0, 1, 2'b10);
        applyStimulus("rem_ovf",   F3_REM,    4'h8, 4'hF, 4'h0, 1'b0, 1, 2'b10);

        // Abort an op two cycles into BUSY.
        @(negedge clk);
        bus.MulDivValid = 1'b1;
        bus.Funct3 = F3_MUL;
        bus.RS1 = 4'h3;
        bus.RS2 = 4'h4;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("abort/inflight", 32'(bus.Start), 32'd1);
        reset = 1'b1;
        bus.MulDivValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort/start", 32'(bus.Start), 32'd0);
        checkOutput("abort/stall", 32'(bus.Stall), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort/novalid", 32'(bus.ResultValid), 32'd0);
            @(negedge clk);
            #1;
        end

        applyStimulus("mul_34",    F3_MUL,    4'h3, 4'h4, 4'hC, 1'b1, ISSUE_STALL, 2'b00);
        applyStimulus("mulhu_ff2", F3_MULHU,  4'hF, 4'hF, 4'hE, 1'b1, ISSUE_STALL, 2'b01);
        applyStimulus("mul_ff2",   F3_MUL,    4'hF, 4'hF, 4'h1, !REUSE, REUSE ? 1 : ISSUE_STALL, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
